// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// Holds the FSM state encoding, default width and counter sizing helper.
package mult_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration on a 2W-bit {acc, multiplier} register.
// Ports: pp_i current partial, mcand_i multiplicand magnitude, pp_o next partial.
module mult_step
  import mult_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [2*W-1:0] pp_i,
  input  logic [W-1:0]   mcand_i,
  output logic [2*W-1:0] pp_o
);

  logic [W:0] sum;

  // pp_i[0] is the multiplier bit under consideration; the
  // carry out of the add is kept and shifted into the top.
  always_comb begin
    sum = {1'b0, pp_i[2*W-1:W]};
    if (pp_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    pp_o = {sum, pp_i[W-1:1]};
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed/unsigned multiplier, one shift-add step per cycle.
// Ports: clk, rst_n, start, is_signed, a, b in; busy, done, result, result_hi out.
module mult_seq
  import mult_pkg::*;
#(
  parameter int width = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [0:width-1] a,
  input  logic [0:width-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:width-1] result,
  output logic [0:width-1] result_hi
);

  localparam int CW = cnt_w(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [width-1:0]  mcand_q;
  logic [2*width-1:0] pp_q;
  logic [2*width-1:0] pp_d;
  logic [2*width-1:0] prod_d;
  logic [2*width-1:0] res_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;

  logic [width-1:0]  a_v;
  logic [width-1:0]  b_v;
  logic [width-1:0]  mag_a;
  logic [width-1:0]  mag_b;
  logic              neg_d;

  // Port bit 0 is the MSB, so a plain copy keeps numeric value.
  assign a_v = a;
  assign b_v = b;

  // Magnitudes fit in width bits unsigned, including |min int|.
  assign mag_a = (is_signed && a_v[width-1]) ? -a_v : a_v;
  assign mag_b = (is_signed && b_v[width-1]) ? -b_v : b_v;
  assign neg_d = is_signed && (a_v[width-1] ^ b_v[width-1]);

  mult_step #(
    .W(width)
  ) u_step (
    .pp_i   (pp_q),
    .mcand_i(mcand_q),
    .pp_o   (pp_d)
  );

  // Final sign fix applied to the last step's output directly,
  // so result lands on the same edge as the last iteration.
  assign prod_d = neg_q ? -pp_d : pp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      pp_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= mag_a;
            pp_q    <= {{width{1'b0}}, mag_b};
            neg_q   <= neg_d;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          pp_q  <= pp_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= prod_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q[width-1:0];
  assign result_hi = res_q[2*width-1:width];

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter: width, 32, operand and result width in bits.
REQ-002 All vector ports SHALL be declared [0:width-1]; bit 0 is the MSB.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled on the rising edge of clk.
REQ-006 is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-007 a  input  width  multiplicand.
REQ-008 b  input  width  multiplier.
REQ-009 busy  output  1  high while an operation is accepted and in progress.
REQ-010 done  output  1  one-cycle pulse; result and result_hi are valid.
REQ-011 result  output  width  low half of the 2*width-bit product.
REQ-012 result_hi  output  width  high half of the 2*width-bit product.

Function
REQ-013 States: IDLE, RUN, DONE; encoding SHALL come from the shared package.
REQ-014 IDLE with start=1 at an edge: latch a, b, is_signed; state -> RUN; busy=1 from that edge; iteration counter = 0.
REQ-015 RUN: one radix-2 shift-add step per cycle on operand magnitudes; counter increments by 1 each cycle.
REQ-016 RUN with counter = width-1 at an edge: state -> DONE; result/result_hi updated to the final product at that same edge.
REQ-017 Latency: start high in cycle 0 SHALL give done high in cycle width+1 exactly; busy high in cycles 1..width.
REQ-018 DONE: done=1, busy=0 for exactly one cycle; next state is IDLE, or RUN if start=1 in that cycle (back-to-back acceptance, no idle gap).
REQ-019 start while in RUN SHALL be ignored: no relatch, no restart, counter undisturbed.
REQ-020 Signed mode: magnitudes taken as unsigned width-bit values (|0x80000000| = 2^31 representable); final product negated over 2*width bits when operand signs differ.
REQ-021 Unsigned mode: full 2*width-bit unsigned product; no overflow flag.
REQ-022 result and result_hi SHALL hold their last final value from DONE until the next DONE; no intermediate partial products on these ports.
REQ-023 a, b, is_signed changes after acceptance SHALL NOT affect the operation in flight.
REQ-024 Zero operand SHALL still take the full width+1 latency; no early termination.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, counter 0, busy=0, done=0, result=0, result_hi=0, all internal operand/partial registers 0.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no done pulse for it after release.
REQ-027 First start is accepted on the first rising edge with rst_n high.

Structure
REQ-028 Shared package mult_pkg SHALL hold: state typedef/encoding (IDLE, RUN, DONE) and default WIDTH constant 32; counter width derived as clog2(width).
REQ-029 One sub-module, mult_step: combinational single shift-add iteration (partial product, multiplier bit -> next partial product); instantiated once in mult_seq.
REQ-030 Sign handling (magnitude, final negation) SHALL live in mult_seq, not mult_step.

Verification
REQ-031 Unsigned 3 x 5, start in cycle 0 -> done in cycle 33 only; result=0x0000000F, result_hi=0x00000000; busy high cycles 1..32.
REQ-032 Signed -2 x 3 (0xFFFFFFFE, 0x00000003) -> result=0xFFFFFFFA, result_hi=0xFFFFFFFF; same inputs unsigned -> result=0xFFFFFFFA, result_hi=0x00000002.
REQ-033 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001, result_hi=0xFFFFFFFE; signed 0x80000000 x 0xFFFFFFFF -> result=0x80000000, result_hi=0x00000000.
REQ-034 start pulsed at cycle 10 of a 3 x 5 operation with a=7, b=7 -> ignored; done in cycle 33 with 0x0000000F; no second done.
REQ-035 start held in DONE cycle with 2 x 4 -> done in cycle 33 (15), next done in cycle 66 with result=0x00000008; busy low only in cycle 33.
REQ-036 rst_n low for one cycle mid-RUN (cycle 16) -> busy, done, result, result_hi = 0 immediately; no done for aborted operation; new 6 x 7 afterwards -> 0x0000002A at width+1 cycles after its start.
